// File: rtl/branch_resolver_if.sv
// Bundles the ID-side prediction, EX-side outcome and redirect/statistics signals of the branch resolver.
// The pipeline side is the master modport; the resolver is the slave modport.
interface branch_resolver_if #(
  parameter int CNT_W = 16
);
  logic             stall;
  logic             id_valid;
  logic [31:0]      ID_PC;
  logic [31:0]      ID_IR;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic [31:0]      EX_PC;
  logic             is_jump;
  logic             do_jump;
  logic [31:0]      jump_address;
  logic             jump_test;
  logic [31:0]      redirect_pc;
  logic             flush_id;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mispred_count;
  logic [CNT_W-1:0] taken_count;

  modport master (
    output stall, id_valid, ID_PC, ID_IR, pred_taken, pred_target,
           EX_PC, is_jump, do_jump, jump_address,
    input  jump_test, redirect_pc, flush_id, br_count, mispred_count, taken_count
  );

  modport slave (
    input  stall, id_valid, ID_PC, ID_IR, pred_taken, pred_target,
           EX_PC, is_jump, do_jump, jump_address,
    output jump_test, redirect_pc, flush_id, br_count, mispred_count, taken_count
  );
endinterface

// File: rtl/branch_resolver.sv
// EX-stage branch resolver: carries the ID prediction into EX, flags mispredicts combinationally,
// spends one non-stalled cycle in RECOVER on the squashed slot, and keeps saturating accuracy counters.
module branch_resolver #(
  parameter int         CNT_W  = 16,
  parameter logic [5:0] JMP_OP = 6'b000010,
  parameter logic [5:0] BR_OP  = 6'b111111
) (
  input  logic             clk,
  input  logic             rst,
  branch_resolver_if.slave bus
);

  typedef enum logic {RUN, RECOVER} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic             rec_valid;
  logic             rec_taken;
  logic [31:0]      rec_pc;
  logic [31:0]      rec_target;
  logic             id_is_br;
  logic             eff_taken;
  logic             res;
  logic             mispredict;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] mis_cnt;
  logic [CNT_W-1:0] tk_cnt;
  logic [25:0]      unused_ir_low;

  assign unused_ir_low = bus.ID_IR[25:0];
  assign id_is_br      = (bus.ID_IR[31:26] == JMP_OP) || (bus.ID_IR[31:26] == BR_OP);
  // A stale record (PC mismatch) is treated as a not-taken prediction.
  assign eff_taken     = rec_valid & rec_taken & (rec_pc == bus.EX_PC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rec_valid  <= 1'b0;
      rec_taken  <= 1'b0;
      rec_pc     <= '0;
      rec_target <= '0;
    end else if (!bus.stall) begin
      rec_valid  <= bus.id_valid & ~mispredict & id_is_br;
      rec_taken  <= bus.pred_taken;
      rec_pc     <= bus.ID_PC;
      rec_target <= bus.pred_target;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    res        = 1'b0;
    mispredict = 1'b0;
    case (state)
      RUN: begin
        res        = bus.is_jump & ~bus.stall;
        mispredict = res & ((eff_taken != bus.do_jump) |
                            (eff_taken & bus.do_jump & (rec_target != bus.jump_address)));
        if (mispredict) state_nxt = RECOVER;
      end
      RECOVER: begin
        if (!bus.stall) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_cnt  <= '0;
      mis_cnt <= '0;
      tk_cnt  <= '0;
    end else if (res) begin
      if (br_cnt != '1)                 br_cnt  <= br_cnt + CNT_ONE;
      if (bus.do_jump && tk_cnt != '1)  tk_cnt  <= tk_cnt + CNT_ONE;
      if (mispredict && mis_cnt != '1)  mis_cnt <= mis_cnt + CNT_ONE;
    end
  end

  assign bus.jump_test     = mispredict;
  assign bus.flush_id      = mispredict;
  assign bus.redirect_pc   = bus.do_jump ? bus.jump_address : bus.EX_PC + 32'd4;
  assign bus.br_count      = br_cnt;
  assign bus.mispred_count = mis_cnt;
  assign bus.taken_count   = tk_cnt;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: expected redirect outputs queued at drive time, popped at the negedge.
module tb_branch_resolver;

  localparam int         CNT_W  = 4;
  localparam logic [5:0] JMP_OP = 6'b000010;
  localparam logic [5:0] BR_OP  = 6'b111111;

  typedef struct {
    logic        jt;
    logic [31:0] rpc;
    logic        fl;
  } exp_t;

  logic clk;
  logic rst;
  logic clk_en;
  int   vectors;
  int   miscompares;
  exp_t sb[$];

  branch_resolver_if #(.CNT_W(CNT_W)) bus();

  branch_resolver #(.CNT_W(CNT_W), .JMP_OP(JMP_OP), .BR_OP(BR_OP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic jt, input logic [31:0] rpc);
    exp_t e;
    e.jt  = jt;
    e.rpc = rpc;
    e.fl  = jt;
    sb.push_back(e);
  endtask

  // Sample combinational outputs mid-cycle and compare against the oldest queued expectation.
  task automatic sb_check(input string tag);
    exp_t e;
    @(negedge clk);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_jump_test"}, {31'd0, bus.jump_test}, {31'd0, e.jt});
      chk({tag, "_redirect"},  bus.redirect_pc,        e.rpc);
      chk({tag, "_flush_id"},  {31'd0, bus.flush_id},  {31'd0, e.fl});
    end
  endtask

  task automatic cnts(input string tag, input int br, input int tk, input int mis);
    chk({tag, "_br"},  32'(bus.br_count),      32'(br));
    chk({tag, "_tk"},  32'(bus.taken_count),   32'(tk));
    chk({tag, "_mis"}, 32'(bus.mispred_count), 32'(mis));
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one prediction in ID, then resolve it in EX the following cycle.
  task automatic resolve(input string tag, input logic [5:0] op, input logic [31:0] id_pc,
                         input logic pt, input logic [31:0] ptgt, input logic [31:0] ex_pc,
                         input logic dj, input logic [31:0] ja,
                         input logic exp_jt, input logic [31:0] exp_rpc);
    bus.id_valid    = 1'b1;
    bus.ID_PC       = id_pc;
    bus.ID_IR       = {op, 26'h0};
    bus.pred_taken  = pt;
    bus.pred_target = ptgt;
    bus.is_jump     = 1'b0;
    next_cyc();
    bus.id_valid     = 1'b0;
    bus.EX_PC        = ex_pc;
    bus.is_jump      = 1'b1;
    bus.do_jump      = dj;
    bus.jump_address = ja;
    push(exp_jt, exp_rpc);
    sb_check(tag);
    next_cyc();
    bus.is_jump = 1'b0;
  endtask

  initial begin
    clk = 1'b0; clk_en = 1'b0; rst = 1'b1;
    vectors = 0; miscompares = 0;
    bus.stall = 1'b0; bus.id_valid = 1'b0; bus.ID_PC = '0; bus.ID_IR = '0;
    bus.pred_taken = 1'b0; bus.pred_target = '0; bus.EX_PC = 32'h200;
    bus.is_jump = 1'b0; bus.do_jump = 1'b0; bus.jump_address = '0;

    // Asynchronous reset with the clock idle.
    #3 rst = 1'b0;
    #1;
    chk("rst_jump_test", {31'd0, bus.jump_test}, 32'd0);
    chk("rst_flush_id",  {31'd0, bus.flush_id},  32'd0);
    chk("rst_redirect",  bus.redirect_pc,        32'h204);
    cnts("rst", 0, 0, 0);
    #1 rst = 1'b1;
    clk_en = 1'b1;
    next_cyc();

    resolve("ok_taken", JMP_OP, 32'h40, 1'b1, 32'h80, 32'h40, 1'b1, 32'h80, 1'b0, 32'h80);
    cnts("ok_taken", 1, 1, 0);

    resolve("nt_vs_t", BR_OP, 32'h40, 1'b0, 32'h0, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
    bus.is_jump = 1'b1; bus.do_jump = 1'b1; bus.jump_address = 32'h100;
    push(1'b0, 32'h100);
    sb_check("recover");
    next_cyc();
    bus.is_jump = 1'b0;
    cnts("nt_vs_t", 2, 2, 1);

    resolve("t_vs_nt", BR_OP, 32'h40, 1'b1, 32'h80, 32'h40, 1'b0, 32'h80, 1'b1, 32'h44);
    next_cyc();
    cnts("t_vs_nt", 3, 2, 2);

    resolve("wrong_tgt", BR_OP, 32'h40, 1'b1, 32'h80, 32'h40, 1'b1, 32'h90, 1'b1, 32'h90);
    next_cyc();
    cnts("wrong_tgt", 4, 3, 3);

    resolve("pc_mismatch", BR_OP, 32'h40, 1'b1, 32'h80, 32'h50, 1'b1, 32'h80, 1'b1, 32'h80);
    next_cyc();
    cnts("pc_mismatch", 5, 4, 4);

    resolve("ok_not_taken", BR_OP, 32'h60, 1'b0, 32'h0, 32'h60, 1'b0, 32'h0, 1'b0, 32'h64);
    cnts("ok_not_taken", 6, 4, 4);

    resolve("non_branch_id", 6'b000000, 32'h40, 1'b1, 32'h80, 32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
    next_cyc();
    cnts("non_branch_id", 7, 5, 5);

    // Stall: record and counters hold while a different ID instruction is offered.
    bus.id_valid = 1'b1; bus.ID_PC = 32'h40; bus.ID_IR = {BR_OP, 26'h0};
    bus.pred_taken = 1'b1; bus.pred_target = 32'h80;
    next_cyc();
    bus.stall = 1'b1; bus.is_jump = 1'b1; bus.EX_PC = 32'h40; bus.do_jump = 1'b0;
    bus.jump_address = 32'h0; bus.ID_PC = 32'h99; bus.pred_taken = 1'b0; bus.pred_target = 32'h0;
    for (int i = 0; i < 3; i++) begin
      push(1'b0, 32'h44);
      sb_check("stall");
      next_cyc();
    end
    cnts("stall", 7, 5, 5);
    bus.stall = 1'b0; bus.id_valid = 1'b0; bus.do_jump = 1'b1; bus.jump_address = 32'h80;
    push(1'b0, 32'h80);
    sb_check("stall_release");
    next_cyc();
    bus.is_jump = 1'b0;
    cnts("stall_release", 8, 6, 5);

    // Reset while in RECOVER drops back to RUN.
    bus.EX_PC = 32'h70; bus.is_jump = 1'b1; bus.do_jump = 1'b1; bus.jump_address = 32'h300;
    push(1'b1, 32'h300);
    sb_check("pre_rst_mis");
    next_cyc();
    bus.is_jump = 1'b0;
    cnts("pre_rst_mis", 9, 7, 6);
    #2 rst = 1'b0;
    #1;
    cnts("mid_rst", 0, 0, 0);
    rst = 1'b1;
    bus.is_jump = 1'b1; bus.jump_address = 32'h310;
    push(1'b1, 32'h310);
    sb_check("post_rst_run");
    next_cyc();
    bus.is_jump = 1'b0;
    cnts("post_rst_run", 1, 1, 1);
    next_cyc();

    // Saturation of the branch counter at CNT_W=4.
    rst = 1'b0;
    #1 rst = 1'b1;
    bus.EX_PC = 32'h80; bus.is_jump = 1'b1; bus.do_jump = 1'b0;
    for (int i = 0; i < 16; i++) begin
      push(1'b0, 32'h84);
      sb_check("sat");
      next_cyc();
      if (i == 14) chk("sat_br_15", 32'(bus.br_count), 32'hF);
    end
    bus.is_jump = 1'b0;
    cnts("sat_16", 15, 0, 0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- EX-stage counterpart of the ID-stage branch predictor.
- Carries each ID-stage prediction (taken flag and target) alongside its instruction into EX, then checks it against the real branch outcome.
- On a wrong prediction it raises the redirect/flush request that the PC mux consumes (`jump_test`, `redirect_pc`).
- Keeps saturating statistics counters for prediction accuracy.

Parameters:
- `CNT_W`, 16, width of each statistics counter.
- `JMP_OP`, 6'b000010, opcode of unconditional jump `j`.
- `BR_OP`, 6'b111111, opcode of the conditional branch.

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `stall`  in  1  pipeline hold; ID→EX does not advance, no resolution this cycle
- `id_valid`  in  1  ID stage holds a real (non-bubble) instruction
- `ID_PC`  in  32  PC of the instruction in ID
- `ID_IR`  in  32  instruction in ID
- `pred_taken`  in  1  predictor steered fetch to its BTB target for the ID instruction
- `pred_target`  in  32  BTB target used when `pred_taken`=1
- `EX_PC`  in  32  PC of the instruction in EX
- `is_jump`  in  1  EX instruction is a jump/branch
- `do_jump`  in  1  EX branch actually taken (valid when `is_jump`)
- `jump_address`  in  32  actual target computed in EX
- `jump_test`  out  1  mispredict: override next PC with `redirect_pc`
- `redirect_pc`  out  32  correct next PC after a mispredict
- `flush_id`  out  1  squash the wrong-path instruction now in ID
- `br_count`  out  `CNT_W`  branches resolved
- `mispred_count`  out  `CNT_W`  mispredictions detected
- `taken_count`  out  `CNT_W`  resolved branches actually taken

Behaviour:
- **Prediction record** (EX side), registered fields:
  - `rec_valid`, `rec_pc`, `rec_taken`, `rec_target`.
  - On a rising edge with `stall`=0, the record loads `{id_valid & ~flush_id & id_is_br, ID_PC, pred_taken, pred_target}`.
  - `id_is_br` = (`ID_IR[31:26]` == `JMP_OP` or `BR_OP`).
  - `stall`=1: record holds its value.
- **Effective prediction**:
  - `eff_taken` = `rec_valid & rec_taken & (rec_pc == EX_PC)`.
  - A record whose PC does not match `EX_PC` counts as "predicted not-taken".
- **Resolution** (`res`) = `is_jump & ~stall & (state == RUN)`. All of the following are combinational in the same cycle:
  - `mispredict` = `res & ((eff_taken != do_jump) | (eff_taken & do_jump & (rec_target != jump_address)))`.
  - `jump_test` = `flush_id` = `mispredict`.
  - `redirect_pc` = `do_jump` ? `jump_address` : `EX_PC + 4` (modulo 2^32). It is driven at all times and is meaningful only when `jump_test`=1.
- **FSM**, states `RUN` and `RECOVER`:
  - `RUN` → `RECOVER` on `mispredict`.
  - `RECOVER` → `RUN` on the next edge with `stall`=0. If `stall`=1, stay in `RECOVER`.
  - In `RECOVER`, EX holds the squashed wrong-path slot. No resolution, no counter update, `jump_test`=0.
- **Counters** (update on the clock edge when `res`=1, each saturating at all-ones, no wrap):
  - `br_count` +1 on every resolution.
  - `taken_count` +1 when `do_jump`=1.
  - `mispred_count` +1 when `mispredict`=1.
- **Reset** (`rst`=0, takes effect immediately, independent of `clk`):
  - `rec_valid`=0, record fields 0, state=`RUN`, all counters 0.
  - Outputs therefore read `jump_test`=0, `flush_id`=0, `redirect_pc`=`EX_PC`+4.
  - Reset asserted mid-`RECOVER` returns the FSM to `RUN`; an in-flight mispredict is dropped.
- **Simultaneous events**:
  - When mispredict and record load occur on the same edge, the loaded record is invalid (`flush_id` masks it).
  - With `stall`=1 and `is_jump`=1, nothing resolves. Resolution happens on the first edge where `stall`=0.

Test Plan:
- Reset: pulse `rst`=0 mid-cycle, `clk` idle → counters 0, `jump_test`=0, state `RUN` without any clock edge.
- Correct taken prediction: ID `PC`=0x40, `pred_taken`=1, `pred_target`=0x80; next cycle `EX_PC`=0x40, `is_jump`=1, `do_jump`=1, `jump_address`=0x80 → `jump_test`=0; `br_count`=1, `taken_count`=1, `mispred_count`=0.
- Predicted not-taken, actually taken: `pred_taken`=0, `do_jump`=1, `jump_address`=0x100, `EX_PC`=0x40 → `jump_test`=1, `redirect_pc`=0x100, `flush_id`=1; next cycle in `RECOVER`, `jump_test`=0 even if `is_jump`=1; `mispred_count`=1.
- Predicted taken, actually not taken: `pred_taken`=1, `pred_target`=0x80, `do_jump`=0, `EX_PC`=0x40 → `redirect_pc`=0x44, `jump_test`=1.
- Wrong target: predicted taken to 0x80, actual taken to 0x90 → `jump_test`=1, `redirect_pc`=0x90. Record `PC` mismatch (`rec_pc`=0x40, `EX_PC`=0x50, `do_jump`=1) → treated as not-taken, mispredict.
- Stall and saturation: hold `stall`=1 with `is_jump`=1 for 3 cycles → record and counters unchanged, `jump_test`=0. Preload at `CNT_W`=4 with 15 resolutions → `br_count` stays 0xF on the 16th.
